// File: rtl/ant_iq_write_sequencer_if.sv
// rtl/ant_iq_write_sequencer_if.sv - RE input stream and antenna-buffer write bus interfaces
// ant_iq_stream_if: per-symbol RE stream into the sequencer
//   data  ANT*32  RE data, lane a = bits [a*32 +: 32]
//   vld   1       beat valid, gaps allowed
//   sop   1       first RE of a symbol, qualified by vld
//   eop   1       last RE of a symbol, qualified by vld
// ant_iq_write_if: write bus into the even/odd antenna buffer
//   addr  ADDR_WIDTH  RE write address
//   data  ANT*32      write data
//   vld   1           write enable
//   last  1           final beat of packet
interface ant_iq_stream_if #(
  parameter int ANT = 4
);
  logic [ANT*32-1:0] data;
  logic              vld;
  logic              sop;
  logic              eop;

  modport master (output data, vld, sop, eop);
  modport slave  (input  data, vld, sop, eop);
endinterface

interface ant_iq_write_if #(
  parameter int ANT        = 4,
  parameter int ADDR_WIDTH = 11
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [ANT*32-1:0]     data;
  logic                  vld;
  logic                  last;

  modport master (output addr, data, vld, last);
  modport slave  (input  addr, data, vld, last);
endinterface

// File: rtl/ant_iq_write_sequencer.sv
// rtl/ant_iq_write_sequencer.sv - Antenna IQ write sequencer forcing every packet to RE_NUM beats
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   iq_in   (slave)    per-symbol RE stream (data/vld/sop/eop)
//   iq_wr   (master)   buffer write bus (addr/data/vld/last), registered
//   i_hold             downstream cannot take a new packet, sampled at sop only
//   o_ant_sel          0 = even-antenna packet, 1 = odd-antenna packet
//   o_sym_idx          symbol index of the current packet
//   o_drop_cnt         packets dropped at sop because of i_hold, saturating
//   o_err_short        pulse: early eop, or sop mid-packet
//   o_err_long         pulse: no eop on the final RE
module ant_iq_write_sequencer #(
  parameter int ANT        = 4,
  parameter int ADDR_WIDTH = 11,
  parameter int RE_NUM     = 1584,
  parameter int SYM_NUM    = 14
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  ant_iq_stream_if.slave iq_in,
  ant_iq_write_if.master iq_wr,
  input  logic           i_hold,
  output logic           o_ant_sel,
  output logic [3:0]     o_sym_idx,
  output logic [15:0]    o_drop_cnt,
  output logic           o_err_short,
  output logic           o_err_long
);
  localparam int                    DW        = ANT * 32;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RE_NUM - 1);
  localparam logic [3:0]            LAST_SYM  = 4'(SYM_NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAD, DROP} state_t;

  state_t                state, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_nxt;
  logic [DW-1:0]         data_q, data_d;
  logic                  vld_q, vld_d;
  logic                  last_q, last_d;
  logic                  err_s_d, err_l_d, drop_d;

  assign iq_wr.addr = addr_q;
  assign iq_wr.data = data_q;
  assign iq_wr.vld  = vld_q;
  assign iq_wr.last = last_q;

  // addr_q always holds the most recently emitted address, so RUN and PAD
  // both continue from addr_q + 1.
  assign addr_nxt = addr_q + 1'b1;

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    data_d  = data_q;
    vld_d   = 1'b0;
    last_d  = 1'b0;
    err_s_d = 1'b0;
    err_l_d = 1'b0;
    drop_d  = 1'b0;
    case (state)
      IDLE: begin
        if (iq_in.vld && iq_in.sop) begin
          if (i_hold) begin
            drop_d  = 1'b1;
            // A single-beat packet is already complete; nothing left to skip.
            state_d = iq_in.eop ? IDLE : DROP;
          end else begin
            vld_d  = 1'b1;
            addr_d = '0;
            data_d = iq_in.data;
            if (iq_in.eop) begin
              err_s_d = 1'b1;
              state_d = PAD;
            end else begin
              state_d = RUN;
            end
          end
        end
      end
      RUN: begin
        if (iq_in.vld) begin
          if (iq_in.sop) begin
            // New packet mid-packet: it is lost, the current one is padded out.
            err_s_d = 1'b1;
            state_d = PAD;
          end else begin
            vld_d  = 1'b1;
            addr_d = addr_nxt;
            data_d = iq_in.data;
            if (addr_nxt == LAST_ADDR) begin
              last_d = 1'b1;
              if (iq_in.eop) begin
                state_d = IDLE;
              end else begin
                err_l_d = 1'b1;
                state_d = DROP;
              end
            end else if (iq_in.eop) begin
              err_s_d = 1'b1;
              state_d = PAD;
            end
          end
        end
      end
      PAD: begin
        vld_d  = 1'b1;
        addr_d = addr_nxt;
        data_d = '0;
        if (addr_nxt == LAST_ADDR) begin
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
      DROP: begin
        if (iq_in.vld && iq_in.eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      o_err_short <= 1'b0;
      o_err_long  <= 1'b0;
      o_drop_cnt  <= '0;
      o_ant_sel   <= 1'b0;
      o_sym_idx   <= '0;
    end else begin
      state       <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      o_err_short <= err_s_d;
      o_err_long  <= err_l_d;
      if (drop_d && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      // Keyed off the registered last so the toggle lands one cycle after
      // the last beat and sel/idx stay stable across the whole packet.
      if (last_q) begin
        o_ant_sel <= ~o_ant_sel;
        if (o_ant_sel) o_sym_idx <= (o_sym_idx == LAST_SYM) ? 4'd0 : o_sym_idx + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_ant_iq_write_sequencer.sv
// tb/tb_ant_iq_write_sequencer.sv - Directed self-checking bench for ant_iq_write_sequencer
module tb_ant_iq_write_sequencer;
  localparam int ANT = 4, AW = 11, RE = 1584, SYM = 14, DW = ANT * 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hold = 1'b0;
  logic        ant_sel;
  logic [3:0]  sym_idx;
  logic [15:0] drop_cnt;
  logic        err_short, err_long;

  ant_iq_stream_if #(.ANT(ANT)) s_if();
  ant_iq_write_if #(.ANT(ANT), .ADDR_WIDTH(AW)) w_if();

  ant_iq_write_sequencer #(.ANT(ANT), .ADDR_WIDTH(AW), .RE_NUM(RE), .SYM_NUM(SYM)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .iq_in(s_if), .iq_wr(w_if), .i_hold(hold),
    .o_ant_sel(ant_sel), .o_sym_idx(sym_idx), .o_drop_cnt(drop_cnt),
    .o_err_short(err_short), .o_err_long(err_long));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int n_es = 0, n_el = 0, es_cyc = -1, el_cyc = -1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
    logic          ant;
    logic [3:0]    sym;
    int            cyc;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    logic vld, sop, eop, hold;
    logic [DW-1:0] data;
    logic e_vld, e_last;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic e_es, e_el;
    logic [15:0] e_drop;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (w_if.vld) beats.push_back('{w_if.addr, w_if.data, w_if.last, ant_sel, sym_idx, cyc});
    if (err_short) begin n_es++; es_cyc = cyc; end
    if (err_long)  begin n_el++; el_cyc = cyc; end
    if (w_if.last) chk("last_implies_vld", w_if.vld, 1);
  end

  function automatic logic [DW-1:0] mkdata(input int p, input int k);
    logic [DW-1:0] d;
    for (int a = 0; a < ANT; a++) d[a*32 +: 32] = 32'((p << 24) | (k << 4) | a);
    return d;
  endfunction

  task automatic cyc_in(input logic v, input logic s, input logic e, input logic [DW-1:0] d);
    s_if.vld = v; s_if.sop = s; s_if.eop = e; s_if.data = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc_in(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_pkt(input int n, input int p, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 7) == 0) idle();
      cyc_in(1'b1, k == 0, k == n - 1, mkdata(p, k));
    end
  endtask

  task automatic do_reset();
    hold = 1'b0;
    s_if.vld = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0; s_if.data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    beats.delete(); n_es = 0; n_el = 0; es_cyc = -1; el_cyc = -1;
  endtask

  task automatic wait_beats(input string name, input int n, input int budget);
    int c = 0;
    while (beats.size() < n && c < budget) begin idle(); c++; end
    idle(); idle();
    chk({name, " beat_count"}, beats.size(), n);
  endtask

  // Expected packet: addr 0..RE-1, last only on RE-1, input data for the
  // first n_data beats and zero after, constant ant_sel/sym_idx.
  task automatic check_pkt(input string name, input int qi, input int n_data, input int p,
                           input logic ant, input int sym);
    int bad = 0;
    beat_t b;
    logic [DW-1:0] ed;
    if (beats.size() < qi + RE) begin
      chk({name, " size"}, beats.size(), qi + RE);
      return;
    end
    for (int j = 0; j < RE; j++) begin
      b = beats[qi + j];
      ed = (j < n_data) ? mkdata(p, j) : '0;
      if (b.addr != AW'(j) || b.last != (j == RE - 1) || b.data != ed ||
          b.ant != ant || b.sym != 4'(sym)) bad++;
    end
    chk({name, " bad_beats"}, bad, 0);
  endtask

  initial begin
    #1_500_000;
    errors++; checks++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    logic [DW-1:0] da, dx;
    da = mkdata(99, 0);
    dx = mkdata(98, 5);

    // Reset state
    do_reset();
    chk("rst vld", w_if.vld, 0);
    chk("rst last", w_if.last, 0);
    chk("rst addr", w_if.addr, 0);
    chk("rst data_zero", w_if.data == '0, 1);
    chk("rst ant_sel", ant_sel, 0);
    chk("rst sym_idx", sym_idx, 0);
    chk("rst drop_cnt", drop_cnt, 0);
    chk("rst err_short", err_short, 0);
    chk("rst err_long", err_long, 0);

    // IDLE/DROP corner cases, cycle by cycle
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 11'd0, '0, 1'b0, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, dx, 1'b0, 1'b0, 11'd0, '0, 1'b0, 1'b0, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, dx, 1'b0, 1'b0, 11'd0, '0, 1'b0, 1'b0, 16'd1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, dx, 1'b0, 1'b0, 11'd0, '0, 1'b0, 1'b0, 16'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, dx, 1'b0, 1'b0, 11'd0, '0, 1'b0, 1'b0, 16'd1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, da, 1'b1, 1'b0, 11'd0, da, 1'b1, 1'b0, 16'd1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, dx, 1'b1, 1'b0, 11'd1, '0, 1'b0, 1'b0, 16'd1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 11'd2, '0, 1'b0, 1'b0, 16'd1};
    for (int i = 0; i < 8; i++) begin
      hold = tbl[i].hold;
      cyc_in(tbl[i].vld, tbl[i].sop, tbl[i].eop, tbl[i].data);
      chk($sformatf("tbl%0d vld", i), w_if.vld, tbl[i].e_vld);
      chk($sformatf("tbl%0d last", i), w_if.last, tbl[i].e_last);
      chk($sformatf("tbl%0d err_short", i), err_short, tbl[i].e_es);
      chk($sformatf("tbl%0d err_long", i), err_long, tbl[i].e_el);
      chk($sformatf("tbl%0d drop_cnt", i), drop_cnt, tbl[i].e_drop);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d addr", i), w_if.addr, tbl[i].e_addr);
        chk($sformatf("tbl%0d data_ok", i), w_if.data == tbl[i].e_data, 1);
      end
    end
    hold = 1'b0;
    wait_beats("tbl pad", RE, 3000);
    check_pkt("tbl pad", 0, 1, 99, 1'b0, 0);
    chk("tbl ant_after", ant_sel, 1);
    chk("tbl sym_after", sym_idx, 0);
    chk("tbl n_err_short", n_es, 1);

    // sop in the middle of a packet
    do_reset();
    for (int k = 0; k < 10; k++) cyc_in(1'b1, k == 0, 1'b0, mkdata(20, k));
    cyc_in(1'b1, 1'b1, 1'b0, mkdata(21, 0));
    wait_beats("sopmid", RE, 3000);
    check_pkt("sopmid", 0, 10, 20, 1'b0, 0);
    chk("sopmid n_err_short", n_es, 1);
    chk("sopmid err_cycle", es_cyc, beats[9].cyc + 1);
    chk("sopmid pad_start_gap", beats[10].cyc - beats[9].cyc, 2);

    // 1: two full packets back to back
    do_reset();
    send_pkt(RE, 1, 1'b0);
    send_pkt(RE, 2, 1'b0);
    repeat (3) idle();
    chk("t1 size", beats.size(), 2 * RE);
    check_pkt("t1 p0", 0, RE, 1, 1'b0, 0);
    check_pkt("t1 p1", RE, RE, 2, 1'b1, 0);
    chk("t1 ant_after", ant_sel, 0);
    chk("t1 sym_after", sym_idx, 1);
    chk("t1 errs", n_es + n_el, 0);

    // 2: early eop on beat 100, input noise during PAD
    do_reset();
    send_pkt(100, 3, 1'b0);
    for (int k = 0; k < 50; k++) cyc_in(1'b1, k == 10, k == 20, mkdata(9, k));
    wait_beats("t2", RE, 3000);
    check_pkt("t2", 0, 100, 3, 1'b0, 0);
    chk("t2 n_err_short", n_es, 1);
    chk("t2 err_cycle", es_cyc, beats[99].cyc);
    chk("t2 pad_contiguous", beats[RE-1].cyc - beats[99].cyc, RE - 1 - 99);
    chk("t2 ant_after", ant_sel, 1);

    // 3: 1600-beat packet, then a normal one
    do_reset();
    send_pkt(1600, 4, 1'b0);
    send_pkt(RE, 5, 1'b0);
    repeat (3) idle();
    chk("t3 size", beats.size(), 2 * RE);
    check_pkt("t3 p0", 0, RE, 4, 1'b0, 0);
    check_pkt("t3 p1", RE, RE, 5, 1'b1, 0);
    chk("t3 n_err_long", n_el, 1);
    chk("t3 err_cycle", el_cyc, beats[RE-1].cyc);
    chk("t3 n_err_short", n_es, 0);

    // 4: hold at sop drops the packet
    do_reset();
    hold = 1'b1;
    send_pkt(RE, 6, 1'b0);
    hold = 1'b0;
    repeat (2) idle();
    chk("t4 no_beats", beats.size(), 0);
    chk("t4 drop_cnt", drop_cnt, 1);
    chk("t4 ant", ant_sel, 0);
    chk("t4 sym", sym_idx, 0);
    send_pkt(RE, 7, 1'b0);
    repeat (3) idle();
    chk("t4 size", beats.size(), RE);
    check_pkt("t4 next", 0, RE, 7, 1'b0, 0);

    // 5: 28 packets with random gaps, full symbol cycle
    do_reset();
    for (int p = 0; p < 28; p++) send_pkt(RE, 10 + p, 1'b1);
    repeat (3) idle();
    chk("t5 size", beats.size(), 28 * RE);
    for (int p = 0; p < 28; p++)
      check_pkt($sformatf("t5 p%0d", p), p * RE, RE, 10 + p, 1'(p % 2), p / 2);
    chk("t5 sym_wrap", sym_idx, 0);
    chk("t5 ant", ant_sel, 0);

    // 6: asynchronous reset mid-packet
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(RE, 30 + p, 1'b0);
    hold = 1'b1;
    send_pkt(5, 33, 1'b0);
    hold = 1'b0;
    for (int k = 0; k <= 500; k++) cyc_in(1'b1, k == 0, 1'b0, mkdata(34, k));
    chk("t6 pre addr", w_if.addr, 500);
    chk("t6 pre ant", ant_sel, 1);
    chk("t6 pre sym", sym_idx, 1);
    chk("t6 pre drop", drop_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async vld", w_if.vld, 0);
    chk("t6 async addr", w_if.addr, 0);
    chk("t6 async data_zero", w_if.data == '0, 1);
    chk("t6 async ant", ant_sel, 0);
    chk("t6 async sym", sym_idx, 0);
    chk("t6 async drop", drop_cnt, 0);
    s_if.vld = 1'b0; s_if.sop = 1'b0; s_if.eop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    beats.delete();
    send_pkt(RE, 35, 1'b0);
    repeat (3) idle();
    chk("t6 size", beats.size(), RE);
    check_pkt("t6 after", 0, RE, 35, 1'b0, 0);
    chk("t6 drop_after", drop_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
